// File: rtl/dbus_sram_responder.sv
// rtl/dbus_sram_responder.sv - word-addressed SRAM responder for the core data bus
package dbus_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;
endpackage

module dbus_sram_responder
  import dbus_pkg::*;
#(
  parameter int ADDR_BITS    = 10,
  parameter int ACCEPT_DELAY = 0,
  parameter int LATENCY      = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       busy
);
  localparam int          DEPTH       = 1 << ADDR_BITS;
  localparam logic [15:0] HOLD_TARGET = 16'(ACCEPT_DELAY);
  localparam logic [3:0]  LAT_LOAD    = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, HOLD, WAIT} state_t;

  state_t               state, next_state;
  logic [15:0]          hold_cnt;
  logic [3:0]           lat_cnt;
  logic [ADDR_BITS-1:0] idx_q;
  logic [31:0]          data_hold;
  logic [31:0]          mem [DEPTH];
  logic                 addr_ok;
  logic                 data_ok;
  logic [ADDR_BITS-1:0] req_idx;
  logic                 unused_req_bits;

  // Upper address bits alias onto the same words; byte offset and size play no part.
  assign req_idx         = dreq.addr[ADDR_BITS+1:2];
  assign unused_req_bits = ^{dreq.size, dreq.addr[31:ADDR_BITS+2], dreq.addr[1:0]};

  // Next state and the one-cycle handshake strobes; reset masks both strobes.
  always_comb begin
    next_state = state;
    addr_ok    = 1'b0;
    data_ok    = 1'b0;
    case (state)
      IDLE, HOLD: begin
        if (!dreq.valid) begin
          next_state = IDLE;
        end else if (hold_cnt == HOLD_TARGET) begin
          addr_ok    = 1'b1;
          next_state = WAIT;
        end else begin
          next_state = HOLD;
        end
      end
      WAIT: begin
        if (lat_cnt == 4'd0) begin
          data_ok    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    if (reset) begin
      addr_ok    = 1'b0;
      data_ok    = 1'b0;
      next_state = IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Accept-delay counter: counts consecutive valid cycles while not busy.
  always_ff @(posedge clk) begin
    if (reset || addr_ok || !dreq.valid || state == WAIT) hold_cnt <= 16'd0;
    else                                                  hold_cnt <= hold_cnt + 16'd1;
  end

  // Latency counter and latched word index for the outstanding transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_cnt <= 4'd0;
      idx_q   <= '0;
    end else if (addr_ok) begin
      lat_cnt <= LAT_LOAD;
      idx_q   <= req_idx;
    end else if (state == WAIT && lat_cnt != 4'd0) begin
      lat_cnt <= lat_cnt - 4'd1;
    end
  end

  // Keeps the last returned word on the bus between responses.
  always_ff @(posedge clk) begin
    if (reset)        data_hold <= 32'd0;
    else if (data_ok) data_hold <= mem[idx_q];
  end

  // Byte-strobed write committed at the accept edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (addr_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (dreq.strobe[b]) mem[req_idx][8*b +: 8] <= dreq.data[8*b +: 8];
      end
    end
  end

  assign dresp.addr_ok = addr_ok;
  assign dresp.data_ok = data_ok;
  assign dresp.data    = data_ok ? mem[idx_q] : data_hold;
  assign busy          = addr_ok | ((state == WAIT) & ~reset);

endmodule
